// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: access-size encodings, FSM states, timeout default.
package mem_stage_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

    // funct3[1:0] selects the access size, funct3[2] selects zero extension on loads
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam int         F3_UNSIGNED = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT_RESP
    } state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the memory stage and the data memory.
interface mem_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: store byte enables and data replication, load lane extraction.
module mem_lane_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sign_ext;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        sign_ext = ~funct3[F3_UNSIGNED];
    end

    always_comb begin
        be        = 4'b1111;
        wdata     = store_data;
        load_data = rdata;
        case (funct3[1:0])
            SZ_B: begin
                be        = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            end
            SZ_H: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata     = {2{store_data[15:0]}};
                load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
            end
            default: begin
                be        = 4'b1111;
                wdata     = store_data;
                load_data = rdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: sequences data-memory accesses, aborts on timeout, registers MEM/WB.
// Define MEM_STAGE_MISALIGN_EN to trap misaligned H/W accesses instead of truncating the address.
//   state        | meaning
//   ST_IDLE      | pass ALU results through; latch a memory op and start it
//   ST_ACCESS    | request on the bus, held stable until accepted
//   ST_WAIT_RESP | load accepted, waiting for read data
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ex_valid,
    input  logic [31:0]        ex_alu_result,
    input  logic [31:0]        ex_rs2_data,
    input  logic [4:0]         ex_rd,
    input  logic [2:0]         ex_funct3,
    input  logic               ex_reg_write,
    input  logic               ex_mem_read,
    input  logic               ex_mem_write,
    mem_stage_if.master        dmem,
    output logic               mem_stall,
    output logic               wb_valid,
    output logic               wb_reg_write,
    output logic [4:0]         wb_rd,
    output logic [31:0]        wb_data,
    output logic               misalign,
    output logic               timeout_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TMR_LOAD = CNT_W'(TIMEOUT - 1);

    state_t            state, state_nx;
    logic [31:0]       op_addr, op_data;
    logic [4:0]        op_rd;
    logic [2:0]        op_funct3;
    logic              op_reg_write, op_load;
    logic [CNT_W-1:0]  tmr;

    logic              ex_mem, misaligned, accept;
    logic [31:0]       eff_addr;
    logic              resp, tmo;
    logic              req_c, we_c, stall_c;
    logic [3:0]        be;
    logic [31:0]       wdata, load_data;

    assign ex_mem = ex_valid & (ex_mem_read | ex_mem_write);

    always_comb begin
        eff_addr = ex_alu_result;
        if (ex_funct3[1:0] == SZ_H)
            eff_addr[0] = 1'b0;
        else if (ex_funct3[1:0] != SZ_B)
            eff_addr[1:0] = 2'b00;
    end

`ifdef MEM_STAGE_MISALIGN_EN
    always_comb begin
        misaligned = 1'b0;
        if (ex_mem) begin
            if (ex_funct3[1:0] == SZ_H)
                misaligned = ex_alu_result[0];
            else if (ex_funct3[1:0] != SZ_B)
                misaligned = |ex_alu_result[1:0];
        end
    end
`else
    assign misaligned = 1'b0;
    assign misalign   = 1'b0;
`endif

    assign accept = ex_mem & ~misaligned;

    // A load that is merely accepted is not a response; only data or store acceptance completes.
    always_comb begin
        resp = 1'b0;
        case (state)
            ST_ACCESS:    resp = op_load ? (dmem.ready & dmem.rvalid) : dmem.ready;
            ST_WAIT_RESP: resp = dmem.rvalid;
            default:      resp = 1'b0;
        endcase
    end

    assign tmo = (state != ST_IDLE) && (tmr == '0) && !resp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (accept)
                    state_nx = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (resp || tmo)
                    state_nx = ST_IDLE;
                else if (op_load && dmem.ready)
                    state_nx = ST_WAIT_RESP;
            end
            ST_WAIT_RESP: begin
                if (resp || tmo)
                    state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        req_c   = 1'b0;
        we_c    = 1'b0;
        stall_c = 1'b0;
        case (state)
            ST_IDLE: stall_c = accept;
            ST_ACCESS: begin
                req_c   = 1'b1;
                we_c    = ~op_load;
                stall_c = ~(resp | tmo);
            end
            ST_WAIT_RESP: stall_c = ~(resp | tmo);
            default: stall_c = 1'b0;
        endcase
        if (!rst_n)
            stall_c = 1'b0;
    end

    assign dmem.req   = req_c;
    assign dmem.we    = we_c;
    assign dmem.addr  = {op_addr[31:2], 2'b00};
    assign dmem.be    = be;
    assign dmem.wdata = wdata;
    assign mem_stall  = stall_c;

    mem_lane_align u_lane (
        .funct3     (op_funct3),
        .addr_lo    (op_addr[1:0]),
        .store_data (op_data),
        .rdata      (dmem.rdata),
        .be         (be),
        .wdata      (wdata),
        .load_data  (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_addr      <= '0;
            op_data      <= '0;
            op_rd        <= '0;
            op_funct3    <= '0;
            op_reg_write <= 1'b0;
            op_load      <= 1'b0;
        end else if (state == ST_IDLE && accept) begin
            op_addr      <= eff_addr;
            op_data      <= ex_rs2_data;
            op_rd        <= ex_rd;
            op_funct3    <= ex_funct3;
            op_reg_write <= ex_reg_write;
            op_load      <= ex_mem_read;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tmr <= '0;
        else if (state == ST_IDLE)
            tmr <= TMR_LOAD;
        else if (tmr != '0)
            tmr <= tmr - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            timeout_err  <= 1'b0;
`ifdef MEM_STAGE_MISALIGN_EN
            misalign     <= 1'b0;
`endif
        end else begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            timeout_err  <= 1'b0;
`ifdef MEM_STAGE_MISALIGN_EN
            misalign     <= 1'b0;
`endif
            if (state == ST_IDLE) begin
                if (ex_valid && !ex_mem) begin
                    wb_valid     <= 1'b1;
                    wb_rd        <= ex_rd;
                    wb_data      <= ex_alu_result;
                    wb_reg_write <= ex_reg_write && (ex_rd != 5'd0);
                end
`ifdef MEM_STAGE_MISALIGN_EN
                else if (misaligned) begin
                    wb_valid <= 1'b1;
                    wb_rd    <= ex_rd;
                    wb_data  <= '0;
                    misalign <= 1'b1;
                end
`endif
            end else if (resp) begin
                wb_valid     <= 1'b1;
                wb_rd        <= op_rd;
                wb_data      <= op_load ? load_data : 32'h0;
                wb_reg_write <= op_load && op_reg_write && (op_rd != 5'd0);
            end else if (tmo) begin
                wb_valid    <= 1'b1;
                wb_rd       <= op_rd;
                wb_data     <= '0;
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed ops, a result scoreboard and literal spot checks.
module tb_mem_stage;

    localparam int TMO = 255;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_rs2_data;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_funct3;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        mem_stall;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign;
    logic        timeout_err;

    mem_stage_if dmem ();

    mem_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_alu_result (ex_alu_result),
        .ex_rs2_data   (ex_rs2_data),
        .ex_rd         (ex_rd),
        .ex_funct3     (ex_funct3),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .dmem          (dmem),
        .mem_stall     (mem_stall),
        .wb_valid      (wb_valid),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .misalign      (misalign),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit run_cmp = 1'b0;

    typedef struct {
        int          due;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] data;
        bit          care;
        bit          tmo;
        bit          mis;
    } exp_t;

    exp_t expq[$];

    logic [3:0]  cap_be;
    logic [31:0] cap_wdata, cap_addr, cap_wb_data;
    logic        cap_we, cap_rw, cap_tmo, cap_mis, cap_req_seen;
    int          cap_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour expressed as arithmetic on whole words
    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * a[1:0])) & 32'hFF;
        h = (w >> (16 * a[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'd128) ? b + 32'hFFFFFF00 : b;
            3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        case (f3[1:0])
            2'b00:   return 4'(32'd1 << a[1:0]);
            2'b01:   return a[1] ? 4'hC : 4'h3;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return (d & 32'hFF) * 32'h01010101;
            2'b01:   return (d & 32'hFFFF) * 32'h00010001;
            default: return d;
        endcase
    endfunction

    always @(negedge clk) begin : cmp
        exp_t e;
        if (run_cmp && rst_n) begin
            if (expq.size() != 0 && expq[0].due == cyc) begin
                e = expq.pop_front();
                chk("wb_valid", 32'(wb_valid), 32'd1);
                chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                chk("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
                if (e.care) chk("wb_data", wb_data, e.data);
                chk("timeout_err", 32'(timeout_err), 32'(e.tmo));
                chk("misalign", 32'(misalign), 32'(e.mis));
            end else begin
                chk("wb_valid_idle", 32'(wb_valid), 32'd0);
                chk("timeout_err_idle", 32'(timeout_err), 32'd0);
                chk("misalign_idle", 32'(misalign), 32'd0);
            end
        end
    end

    task automatic idle();
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        dmem.ready = 1'b0; dmem.rvalid = 1'b0;
        @(negedge clk);
    endtask

    task automatic alu_op(input logic [4:0] rd, input logic [31:0] val, input bit rw);
        exp_t e;
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_alu_result = val; ex_rd = rd; ex_funct3 = 3'b000;
        ex_reg_write = rw; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        e.due = cyc + 1; e.rd = rd; e.rw = rw && (rd != 5'd0); e.data = val;
        e.care = 1'b1; e.tmo = 1'b0; e.mis = 1'b0;
        expq.push_back(e);
        @(negedge clk);
        chk("alu_stall", 32'(mem_stall), 32'd0);
        chk("alu_req", 32'(dmem.req), 32'd0);
    endtask

    // ready_wait: ACCESS cycles before ready; rvalid_wait: cycles after acceptance (-1 = never)
    task automatic mem_op(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [31:0] rdata,
                          input bit rd_en, input bit wr_en, input bit rw,
                          input int ready_wait, input int rvalid_wait);
        bit is_load, mis, fin, timed_out, in_access, resp;
        int n, acc_n;
        exp_t e;
        is_load = rd_en;
        mis = 1'b0;
`ifdef MEM_STAGE_MISALIGN_EN
        mis = (f3[1:0] == 2'b01 && addr[0]) || (f3[1:0] == 2'b10 && addr[1:0] != 2'b00);
`endif
        cap_req_seen = 1'b0;
        cap_stall = 0;
        timed_out = 1'b0;
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_alu_result = addr; ex_rs2_data = sdata; ex_rd = rd;
        ex_funct3 = f3; ex_reg_write = rw; ex_mem_read = rd_en; ex_mem_write = wr_en;
        dmem.ready = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = rdata;
        @(negedge clk);
        chk("issue_req", 32'(dmem.req), 32'd0);
        chk("issue_stall", 32'(mem_stall), 32'(!mis));
        cap_stall += int'(mem_stall);
        e.due = cyc + 1; e.rd = rd; e.mis = mis; e.tmo = 1'b0;
        e.rw = 1'b0; e.data = 32'h0; e.care = 1'b1;
        if (mis) begin
            expq.push_back(e);
        end else begin
            n = 0; acc_n = -1; fin = 1'b0;
            while (!fin) begin
                @(posedge clk); #1;
                n++;
                in_access = (acc_n < 0);
                dmem.ready = in_access && (n - 1 == ready_wait);
                if (dmem.ready) acc_n = n;
                dmem.rvalid = is_load && (acc_n >= 0) && (rvalid_wait >= 0) && (n - acc_n == rvalid_wait);
                resp = is_load ? dmem.rvalid : dmem.ready;
                timed_out = !resp && (n == TMO);
                fin = resp || timed_out;
                @(negedge clk);
                chk("req", 32'(dmem.req), 32'(in_access));
                if (in_access) begin
                    chk("addr", dmem.addr, addr & 32'hFFFFFFFC);
                    chk("we", 32'(dmem.we), 32'(!is_load));
                    if (!is_load) begin
                        chk("be", 32'(dmem.be), 32'(m_be(f3, addr)));
                        chk("wdata", dmem.wdata, m_wdata(f3, sdata));
                    end
                    cap_be = dmem.be; cap_wdata = dmem.wdata; cap_addr = dmem.addr;
                    cap_we = dmem.we; cap_req_seen = cap_req_seen | dmem.req;
                end
                chk("stall", 32'(mem_stall), 32'(!fin));
                cap_stall += int'(mem_stall);
            end
            e.due = cyc + 1; e.tmo = timed_out;
            if (timed_out) begin
                e.rw = 1'b0; e.data = 32'h0; e.care = 1'b1;
            end else if (is_load) begin
                e.rw = rw && (rd != 5'd0); e.data = m_load(f3, addr, rdata); e.care = 1'b1;
            end else begin
                e.rw = 1'b0; e.care = 1'b0;
            end
            expq.push_back(e);
        end
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        dmem.ready = 1'b0; dmem.rvalid = 1'b0;
        @(negedge clk);
        chk("wb_valid_after", 32'(wb_valid), 32'd1);
        cap_wb_data = wb_data; cap_rw = wb_reg_write; cap_tmo = timeout_err; cap_mis = misalign;
    endtask

    initial begin
        rst_n = 1'b0;
        ex_valid = 1'b0; ex_alu_result = '0; ex_rs2_data = '0; ex_rd = '0; ex_funct3 = '0;
        ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        dmem.ready = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(dmem.req), 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        #1 rst_n = 1'b1;
        run_cmp = 1'b1;

        alu_op(5'd5, 32'h11111111, 1'b1);
        alu_op(5'd0, 32'h00000022, 1'b1);
        alu_op(5'd7, 32'h00000033, 1'b0);
        idle();

        // SW 0x100, ready on the second ACCESS cycle
        mem_op(5'd1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 1'b0, 1, -1);
        chk("sw_be", 32'(cap_be), 32'hF);
        chk("sw_we", 32'(cap_we), 32'd1);
        chk("sw_stall_cycles", 32'(cap_stall), 32'd2);
        chk("sw_wb_reg_write", 32'(cap_rw), 32'd0);

        mem_op(5'd3, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 1'b1, 1'b0, 1'b1, 0, 0);
        chk("lb_data", cap_wb_data, 32'hFFFFFF80);
        mem_op(5'd4, 3'b100, 32'h103, 32'h0, 32'h80FFFFFF, 1'b1, 1'b0, 1'b1, 0, 2);
        chk("lbu_data", cap_wb_data, 32'h00000080);

        mem_op(5'd2, 3'b001, 32'h102, 32'h00001234, 32'h0, 1'b0, 1'b1, 1'b0, 0, -1);
        chk("sh_be", 32'(cap_be), 32'hC);
        chk("sh_wdata", cap_wdata, 32'h12341234);

        mem_op(5'd6, 3'b001, 32'h202, 32'h0, 32'h80017FFF, 1'b1, 1'b0, 1'b1, 1, 1);
        mem_op(5'd8, 3'b101, 32'h200, 32'h0, 32'h8001F00F, 1'b1, 1'b0, 1'b1, 0, 0);
        mem_op(5'd9, 3'b000, 32'h201, 32'h000000AB, 32'h0, 1'b0, 1'b1, 1'b0, 2, -1);
        mem_op(5'd0, 3'b010, 32'h104, 32'h0, 32'h12345678, 1'b1, 1'b0, 1'b1, 2, 1);
        mem_op(5'd10, 3'b010, 32'h108, 32'hCAFEF00D, 32'h0BADF00D, 1'b1, 1'b1, 1'b1, 0, 0);
        chk("rw_both_is_load", cap_wb_data, 32'h0BADF00D);

        mem_op(5'd11, 3'b010, 32'h10C, 32'h0, 32'h55555555, 1'b1, 1'b0, 1'b1, 0, -1);
        chk("timeout_pulse", 32'(cap_tmo), 32'd1);
        chk("timeout_wb_data", cap_wb_data, 32'd0);

        mem_op(5'd12, 3'b010, 32'h110, 32'h0, 32'h77777777, 1'b1, 1'b0, 1'b1, 0, TMO - 1);
        chk("resp_beats_timeout", 32'(cap_tmo), 32'd0);
        chk("resp_beats_timeout_data", cap_wb_data, 32'h77777777);

        // Reset while a load sits in WAIT_RESP
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_alu_result = 32'h300; ex_rd = 5'd13; ex_funct3 = 3'b010;
        ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
        @(posedge clk); #1;
        dmem.ready = 1'b1;
        @(negedge clk);
        chk("mid_access_req", 32'(dmem.req), 32'd1);
        @(posedge clk); #1;
        dmem.ready = 1'b0;
        @(negedge clk);
        chk("mid_wait_req", 32'(dmem.req), 32'd0);
        chk("mid_wait_stall", 32'(mem_stall), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req", 32'(dmem.req), 32'd0);
        chk("mid_rst_stall", 32'(mem_stall), 32'd0);
        chk("mid_rst_wb_valid", 32'(wb_valid), 32'd0);
        expq.delete();
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_mem_read = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;

        alu_op(5'd14, 32'hA5A5A5A5, 1'b1);
        idle();
        mem_op(5'd15, 3'b010, 32'h400, 32'h0, 32'h01020304, 1'b1, 1'b0, 1'b1, 0, 1);
        chk("post_rst_load", cap_wb_data, 32'h01020304);

        mem_op(5'd16, 3'b010, 32'h101, 32'h0, 32'hFEEDFACE, 1'b1, 1'b0, 1'b1, 0, 0);
`ifdef MEM_STAGE_MISALIGN_EN
        chk("misalign_pulse", 32'(cap_mis), 32'd1);
        chk("misalign_no_req", 32'(cap_req_seen), 32'd0);
        chk("misalign_rw", 32'(cap_rw), 32'd0);
`else
        chk("unaligned_addr", cap_addr, 32'h100);
        chk("unaligned_no_pulse", 32'(cap_mis), 32'd0);
`endif

        idle();
        idle();
        chk("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
